median_window_3x3: RTL and testbench
====================================

// Module: median_window_3x3
// PURPOSE
//  Raster-scan 3x3 window generator feeding the 9-input bitwise median stage.
//  Accepts one pixel per valid cycle and buffers the two previous image lines.
//  Presents the nine window taps a,b,c,d,e,f,g,h,k plus a window-valid qualifier.
//  Emits only windows that lie fully inside the image; border windows are dropped.
// PARAMETERS
//  DATA_W  16  pixel width; matches the median stage input width
//  IMG_W   64  pixels per line, >= 3
//  IMG_H   64  lines per frame, >= 3
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  pix_in     in   DATA_W  input pixel, raster order
//  pix_valid  in   1       pix_in valid this cycle; no backpressure, always accepted
//  sof        in   1       start of frame; meaningful only with pix_valid
//  a,b,c      out  DATA_W  window top row, left->right (oldest line)
//  d,e,f      out  DATA_W  window middle row, left->right
//  g,h,k      out  DATA_W  window bottom row, left->right (k = newest pixel)
//  win_valid  out  1       taps hold a complete in-image window this cycle
//  frame_end  out  1       one-cycle pulse after last pixel of frame accepted
// BEHAVIOUR
//  Reset:
//   - col, row, all nine taps, win_valid and frame_end clear to 0.
//   - Line buffer contents are not cleared. Stale data is never exposed,
//     because windows are gated by row>=2.
//  Counters:
//   - col is $clog2(IMG_W) bits; row is $clog2(IMG_H) bits.
//   - Position (row,col) is that of the pixel being accepted.
//   - Counters advance only on pix_valid. col wraps IMG_W-1 -> 0 and increments row.
//   - row wraps IMG_H-1 -> 0 at end of frame.
//  sof:
//   - pix_valid&&sof forces the accepted pixel to position (0,0).
//   - Next accepted pixel is then (0,1).
//   - Any partial frame in progress is abandoned; no frame_end is emitted for it.
//  Line buffers:
//   - Two IMG_W-deep arrays lb1 (line row-1) and lb2 (line row-2), indexed by col.
//   - On accept: lb2[col] <= lb1[col] and lb1[col] <= pix_in, read-before-write.
//  Window shift, on accept:
//   - a<=b, b<=c, d<=e, e<=f, g<=h, h<=k.
//   - c<=lb2[col], f<=lb1[col], k<=pix_in (lb values read before update).
//   - Taps hold their values on cycles without pix_valid.
//  win_valid:
//   - Registered. It is 1 in the cycle after accepting a pixel with row>=2 && col>=2, else 0.
//   - Latency is 1 clk from the window's bottom-right pixel to tap presentation.
//   - Deasserts after one cycle even if the next pixel gap is long.
//   - Windows never span a line wrap: col 0 and col 1 pixels never produce win_valid.
//   - Count per frame is exactly (IMG_W-2)*(IMG_H-2).
//  frame_end:
//   - Registered. It is 1 in the cycle after accepting (IMG_H-1, IMG_W-1).
//   - Coincides with the final win_valid.
//  Mid-operation events:
//   - rst mid-frame: the next accepted pixel is (0,0), and no window is issued until row 2.
//   - rst has priority over pix_valid in the same cycle; that pixel is dropped.
//   - Back-to-back frames with no idle cycle are supported. The new frame's row-2
//     windows use its own rows 0/1, since the line buffers are overwritten first.
// TESTING
//  Setup for all scenarios: IMG_W=4, IMG_H=4, pixel = {row,col} nibbles (0xRC),
//  continuous pix_valid, sof on the first pixel.
//  1) Single frame: 4 win_valid pulses. First pulse after 0x22: a..k = 00,01,02,10,11,12,20,21,22.
//     Last pulse after 0x33: a..k = 11,12,13,21,22,23,31,32,33, with frame_end high the same cycle.
//  2) Frame 1 with pix_valid toggled 1/0 every cycle: same 4 windows and values as (1).
//     Taps are stable during gaps, and win_valid is high for exactly one cycle each.
//  3) Assert rst after pixel 0x21: no win_valid until the new frame's 0x22.
//     That window's taps come only from new-frame pixels.
//  4) Send 6 pixels, then sof with pixel 0x00: the partial frame yields no frame_end.
//     The new frame yields exactly 4 windows matching (1).
//  5) Two frames back-to-back, frame 2 pixels = 0x80|{R,C}: frame 2's first window is
//     80,81,82,90,91,92,A0,A1,A2, with no frame 1 values present.
//  6) Check row 2 of a frame: pixels 0x20 and 0x21 do not assert win_valid.
//     Its first window arrives after 0x22.

Source files
------------

// File: rtl/median_window_3x3_if.sv
// Pixel stream in, nine window taps plus qualifiers out, for the 3x3 window generator.
// The master drives pixels; the slave (the window generator) drives the taps.
interface median_window_3x3_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] pix_in;
  logic              pix_valid;
  logic              sof;
  logic [DATA_W-1:0] a, b, c;
  logic [DATA_W-1:0] d, e, f;
  logic [DATA_W-1:0] g, h, k;
  logic              win_valid;
  logic              frame_end;

  modport master (
    output pix_in, pix_valid, sof,
    input  a, b, c, d, e, f, g, h, k, win_valid, frame_end
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output a, b, c, d, e, f, g, h, k, win_valid, frame_end
  );
endinterface

// File: rtl/median_window_3x3.sv
// Raster-scan 3x3 window generator: two line buffers plus a 3x3 tap shift array.
// Only windows lying fully inside the image are qualified by win_valid.
module median_window_3x3 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input logic                clk,
  input logic                rst,
  median_window_3x3_if.slave bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic              w_accept;
  logic              w_col_last;
  logic              w_row_last;
  logic [DATA_W-1:0] w_lb1_rd;
  logic [DATA_W-1:0] w_lb2_rd;

  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] r_lb2 [IMG_W];

  logic [DATA_W-1:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h, r_k;
  logic              r_win_valid;
  logic              r_frame_end;

  // sof relocates the pixel being accepted to (0,0), abandoning any partial frame.
  always_comb begin
    w_accept   = bus.pix_valid;
    w_col      = bus.sof ? '0 : r_col;
    w_row      = bus.sof ? '0 : r_row;
    w_col_last = (w_col == COL_W'(IMG_W - 1));
    w_row_last = (w_row == ROW_W'(IMG_H - 1));
    w_lb1_rd   = r_lb1[w_col];
    w_lb2_rd   = r_lb2[w_col];
  end

  // NOTE: line buffers carry no reset; stale entries are never exposed because
  // windows are only qualified from row 2, after two fresh lines have been written.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      // NOTE: non-blocking writes make lb2 capture lb1's old value (read-before-write).
      r_lb2[w_col] <= w_lb1_rd;
      r_lb1[w_col] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_e         <= '0;
      r_f         <= '0;
      r_g         <= '0;
      r_h         <= '0;
      r_k         <= '0;
      r_win_valid <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      r_frame_end <= 1'b0;
      if (w_accept) begin
        r_col <= w_col_last ? '0 : w_col + COL_W'(1);
        if (w_col_last) begin
          r_row <= w_row_last ? '0 : w_row + ROW_W'(1);
        end else begin
          r_row <= w_row;
        end
        r_a <= r_b;
        r_b <= r_c;
        r_c <= w_lb2_rd;
        r_d <= r_e;
        r_e <= r_f;
        r_f <= w_lb1_rd;
        r_g <= r_h;
        r_h <= r_k;
        r_k <= bus.pix_in;
        // Columns 0 and 1 would pull taps from the previous line, so they never qualify.
        r_win_valid <= (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
        r_frame_end <= w_row_last && w_col_last;
      end
    end
  end

  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.c         = r_c;
  assign bus.d         = r_d;
  assign bus.e         = r_e;
  assign bus.f         = r_f;
  assign bus.g         = r_g;
  assign bus.h         = r_h;
  assign bus.k         = r_k;
  assign bus.win_valid = r_win_valid;
  assign bus.frame_end = r_frame_end;

endmodule

// File: tb/tb_median_window_3x3.sv
// Bench for median_window_3x3 on a 4x4 image: vector table, directed corner cases,
// and randomized traffic against an image-array reference model.
module tb_median_window_3x3;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median_window_3x3_if #(.DATA_W(DW)) bus ();

  median_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the image as received, plus the raster position.
  logic [DW-1:0] img [H][W];
  int            m_row, m_col;
  logic [DW-1:0] exp_tap [9];
  logic          taps_known;
  int            win_cnt, fe_cnt;

  typedef struct {
    logic [DW-1:0] pix;
    logic          sof;
    logic          exp_win;
    logic          exp_fe;
    logic [DW-1:0] exp_tap [9];
  } vec_t;

  vec_t vecs [W*H];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] get_tap(input int i);
    case (i)
      0: return bus.a;
      1: return bus.b;
      2: return bus.c;
      3: return bus.d;
      4: return bus.e;
      5: return bus.f;
      6: return bus.g;
      7: return bus.h;
      default: return bus.k;
    endcase
  endfunction

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
    for (int i = 0; i < 9; i++) exp_tap[i] = '0;
    taps_known = 1'b1;
  endtask

  task automatic check_taps(input string tag);
    for (int i = 0; i < 9; i++) check($sformatf("%s_tap%0d", tag, i), get_tap(i), exp_tap[i]);
  endtask

  // One clock: drive, let the edge pass, then compare against the model.
  task automatic step(input logic valid, input logic [DW-1:0] pix, input logic sof);
    logic ew, ef;
    int   r, c;
    bus.pix_valid = valid;
    bus.pix_in    = pix;
    bus.sof       = sof;
    @(posedge clk);
    #1;
    ew = 1'b0;
    ef = 1'b0;
    if (valid) begin
      r = sof ? 0 : m_row;
      c = sof ? 0 : m_col;
      img[r][c] = pix;
      ew = (r >= 2) && (c >= 2);
      ef = (r == H-1) && (c == W-1);
      if (ew) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_tap[i*3+j] = img[r-2+i][c-2+j];
      end
      taps_known = ew;
      m_col = c + 1;
      m_row = r;
      if (m_col == W) begin
        m_col = 0;
        m_row = (r + 1) % H;
      end
    end
    check("win_valid", bus.win_valid, ew);
    check("frame_end", bus.frame_end, ef);
    if (taps_known) check_taps("taps");
    if (bus.win_valid) win_cnt++;
    if (bus.frame_end) fe_cnt++;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic do_reset(input logic valid_during);
    rst           = 1'b1;
    bus.pix_valid = valid_during;
    bus.pix_in    = 16'hDEAD;
    bus.sof       = 1'b0;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.pix_valid = 1'b0;
    model_reset();
    check("rst_win_valid", bus.win_valid, 1'b0);
    check("rst_frame_end", bus.frame_end, 1'b0);
    check_taps("rst");
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input logic gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, base | DW'((r << 4) | c), (r == 0) && (c == 0));
        if (gaps) step(1'b0, 16'hFFFF, 1'b0);
      end
  endtask

  logic [DW-1:0] first_win [9] = '{16'h00, 16'h01, 16'h02, 16'h10, 16'h11, 16'h12, 16'h20, 16'h21, 16'h22};
  logic [DW-1:0] last_win  [9] = '{16'h11, 16'h12, 16'h13, 16'h21, 16'h22, 16'h23, 16'h31, 16'h32, 16'h33};
  logic [DW-1:0] f2_win    [9] = '{16'h80, 16'h81, 16'h82, 16'h90, 16'h91, 16'h92, 16'hA0, 16'hA1, 16'hA2};

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.sof       = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        vecs[r*W+c].pix     = DW'((r << 4) | c);
        vecs[r*W+c].sof     = (r == 0) && (c == 0);
        vecs[r*W+c].exp_win = (r >= 2) && (c >= 2);
        vecs[r*W+c].exp_fe  = (r == H-1) && (c == W-1);
        for (int i = 0; i < 9; i++)
          vecs[r*W+c].exp_tap[i] = DW'(((r - 2 + i / 3) << 4) | (c - 2 + i % 3));
      end
    win_cnt = 0;
    fe_cnt  = 0;
    @(posedge clk);
    do_reset(1'b0);

    // 1) single frame from the table
    for (int v = 0; v < W*H; v++) begin
      step(1'b1, vecs[v].pix, vecs[v].sof);
      check($sformatf("vec%0d_win", v), bus.win_valid, vecs[v].exp_win);
      check($sformatf("vec%0d_fe", v), bus.frame_end, vecs[v].exp_fe);
      if (vecs[v].exp_win)
        for (int i = 0; i < 9; i++) check($sformatf("vec%0d_tap%0d", v, i), get_tap(i), vecs[v].exp_tap[i]);
      if (v == 10) for (int i = 0; i < 9; i++) check("s1_first_win", get_tap(i), first_win[i]);
      if (v == 15) for (int i = 0; i < 9; i++) check("s1_last_win", get_tap(i), last_win[i]);
    end
    step(1'b0, '0, 1'b0);
    check("s1_win_count", win_cnt, 4);
    check("s1_fe_count", fe_cnt, 1);

    // 2) pix_valid toggling
    win_cnt = 0; fe_cnt = 0;
    send_frame(16'h0000, 1'b1);
    check("s2_win_count", win_cnt, 4);
    check("s2_fe_count", fe_cnt, 1);

    // 3) reset after 0x21, then a fresh frame with distinct values
    for (int v = 0; v < 10; v++) step(1'b1, vecs[v].pix, vecs[v].sof);
    do_reset(1'b1);
    win_cnt = 0;
    for (int v = 0; v < 10; v++) step(1'b1, 16'hC000 | vecs[v].pix, 1'b0);
    check("s3_no_early_win", win_cnt, 0);
    step(1'b1, 16'hC022, 1'b0);
    check("s3_win_after_22", bus.win_valid, 1'b1);
    check("s3_tap_a_new", bus.a, 16'hC000);
    for (int v = 11; v < W*H; v++) step(1'b1, 16'hC000 | vecs[v].pix, 1'b0);

    // 4) partial frame abandoned by sof
    win_cnt = 0; fe_cnt = 0;
    for (int v = 0; v < 6; v++) step(1'b1, vecs[v].pix, vecs[v].sof);
    send_frame(16'h0000, 1'b0);
    step(1'b0, '0, 1'b0);
    check("s4_win_count", win_cnt, 4);
    check("s4_fe_count", fe_cnt, 1);

    // 5) back-to-back frames; frame 2 first window
    send_frame(16'h0000, 1'b0);
    for (int v = 0; v < W*H; v++) begin
      step(1'b1, 16'h0080 | vecs[v].pix + ((v >= 8) ? 16'h0 : 16'h0), vecs[v].sof);
      if (v == 10) for (int i = 0; i < 9; i++) check("s5_f2_first_win", get_tap(i), f2_win[i]);
    end

    // 6) row 2 columns 0/1 never qualify
    for (int v = 0; v < 8; v++) step(1'b1, vecs[v].pix, vecs[v].sof);
    step(1'b1, 16'h20, 1'b0);
    check("s6_col0_no_win", bus.win_valid, 1'b0);
    step(1'b1, 16'h21, 1'b0);
    check("s6_col1_no_win", bus.win_valid, 1'b0);
    step(1'b1, 16'h22, 1'b0);
    check("s6_col2_win", bus.win_valid, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
      else step($urandom_range(0, 9) < 7, DW'($urandom_range(0, 65535)),
                (m_row == 0 && m_col == 0) || ($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
